// File: rtl/calc_seq_if.sv
// Drive/readback bundle between the calc_seq self-test initiator and the calc block.
// master = sequencer side, slave = calc side.
interface calc_seq_if;
   logic        calc_rst;
   logic        calc_btnl;
   logic        calc_btnc;
   logic        calc_btnr;
   logic        calc_btnd;
   logic [15:0] calc_sw;
   logic [15:0] calc_led;

   modport master (
      output calc_rst, calc_btnl, calc_btnc, calc_btnr, calc_btnd, calc_sw,
      input  calc_led
   );

   modport slave (
      input  calc_rst, calc_btnl, calc_btnc, calc_btnr, calc_btnd, calc_sw,
      output calc_led
   );
endinterface

// File: rtl/calc_seq.sv
// Self-test initiator: resets calc, plays a fixed (op, operand, expected) program and tallies mismatches.
// Optional macro CALC_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module calc_seq #(
   parameter int WAIT_CYC  = 2,
   parameter int NUM_STEPS = 9
) (
   input  logic       clk,
   input  logic       btnu,
   input  logic       start,
   calc_seq_if.master cbus,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] step,
   output logic [3:0] err_cnt,
   output logic [3:0] fail_idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_SETUP, S_FIRE, S_WAIT, S_CHECK, S_DONE
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);
   localparam logic [3:0] LAST    = 4'(NUM_STEPS - 1);

   state_t     state;
   logic [3:0] wcnt;

   // Program ROM, drive half: {btnl, btnc, btnr, sw}
   function automatic logic [18:0] rom_drv(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_drv = {3'b010, 16'h354A};
         4'd1:    rom_drv = {3'b011, 16'h1234};
         4'd2:    rom_drv = {3'b001, 16'h1001};
         4'd3:    rom_drv = {3'b000, 16'hF0F0};
         4'd4:    rom_drv = {3'b111, 16'h1FA2};
         4'd5:    rom_drv = {3'b010, 16'h6AA2};
         4'd6:    rom_drv = {3'b101, 16'h0004};
         4'd7:    rom_drv = {3'b110, 16'h0001};
         4'd8:    rom_drv = {3'b100, 16'h46FF};
         default: rom_drv = '0;
      endcase
   endfunction

   function automatic logic [15:0] rom_exp(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_exp = 16'h354A;
         4'd1:    rom_exp = 16'h2316;
         4'd2:    rom_exp = 16'h3317;
         4'd3:    rom_exp = 16'h3010;
         4'd4:    rom_exp = 16'h2FB2;
         4'd5:    rom_exp = 16'h9A54;
         4'd6:    rom_exp = 16'hA540;
         4'd7:    rom_exp = 16'hD2A0;
         4'd8:    rom_exp = 16'h0001;
         default: rom_exp = '0;
      endcase
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v == 4'hF) ? v : v + 4'd1;
   endfunction

   logic [18:0] cur_drv, nxt_drv;
   logic        mismatch, last, stop;
   logic [3:0]  err_nxt;

   assign cur_drv  = rom_drv(step);
   assign nxt_drv  = rom_drv(step + 4'd1);
   assign mismatch = (cbus.calc_led != rom_exp(step));
   assign last     = (step == LAST);
   assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;

`ifdef CALC_SEQ_STOP_ON_FAIL_EN
   assign stop = last || mismatch;
`else
   assign stop = last;
`endif

   always_ff @(posedge clk) begin
      if (btnu) begin
         state          <= S_IDLE;
         wcnt           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         step           <= '0;
         err_cnt        <= '0;
         fail_idx       <= 4'hF;
         cbus.calc_rst  <= 1'b0;
         cbus.calc_btnl <= 1'b0;
         cbus.calc_btnc <= 1'b0;
         cbus.calc_btnr <= 1'b0;
         cbus.calc_btnd <= 1'b0;
         cbus.calc_sw   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state         <= S_RST;
                  cbus.calc_rst <= 1'b1;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  step          <= '0;
                  err_cnt       <= '0;
                  fail_idx      <= 4'hF;
               end
            end
            S_RST: begin
               cbus.calc_rst <= 1'b0;
               {cbus.calc_btnl, cbus.calc_btnc, cbus.calc_btnr, cbus.calc_sw} <= cur_drv;
               state <= S_SETUP;
            end
            S_SETUP: begin
               cbus.calc_btnd <= 1'b1;
               state          <= S_FIRE;
            end
            S_FIRE: begin
               cbus.calc_btnd <= 1'b0;
               wcnt           <= WAIT_LD;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               wcnt <= wcnt - 4'd1;
               if (wcnt == 4'd1) state <= S_CHECK;
            end
            S_CHECK: begin
               err_cnt <= err_nxt;
               if (mismatch && fail_idx == 4'hF) fail_idx <= step;
               // Leaving the program releases every calc drive so the board idles quietly.
               if (stop) begin
                  state          <= S_DONE;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  pass           <= (err_nxt == 4'd0);
                  cbus.calc_btnl <= 1'b0;
                  cbus.calc_btnc <= 1'b0;
                  cbus.calc_btnr <= 1'b0;
                  cbus.calc_sw   <= '0;
               end else begin
                  step  <= step + 4'd1;
                  {cbus.calc_btnl, cbus.calc_btnc, cbus.calc_btnr, cbus.calc_sw} <= nxt_drv;
                  state <= S_SETUP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: behavioural calc model on the bus, table checks of the drive program,
// timing/status checks, directed corner sequences and randomized fault injection.
module tb_calc_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       btnu, start;
   logic       busy, done, pass;
   logic [3:0] step, err_cnt, fail_idx;

   calc_seq_if cbus();

   calc_seq #(.WAIT_CYC(2), .NUM_STEPS(9)) dut (
      .clk(clk), .btnu(btnu), .start(start), .cbus(cbus),
      .busy(busy), .done(done), .pass(pass),
      .step(step), .err_cnt(err_cnt), .fail_idx(fail_idx)
   );

   localparam int FULL_LAT = 1 + 9 * (3 + 2);

   int total = 0;
   int bad   = 0;

   // Behavioural calc: accumulator updated by each execute pulse.
   function automatic logic [15:0] calc_ref(input logic [15:0] a, input logic [2:0] op,
                                            input logic [15:0] b);
      case (op)
         3'b010:  calc_ref = a + b;
         3'b011:  calc_ref = a - b;
         3'b001:  calc_ref = a | b;
         3'b000:  calc_ref = a & b;
         3'b111:  calc_ref = a ^ b;
         3'b101:  calc_ref = a << b[3:0];
         3'b110:  calc_ref = 16'($signed(a) >>> b[3:0]);
         default: calc_ref = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      endcase
   endfunction

   logic [15:0] acc = '0;
   logic [15:0] fault_mask = '0;
   logic [15:0] fault_xor  = '0;

   always @(posedge clk) begin
      if (btnu || cbus.calc_rst) acc <= '0;
      else if (cbus.calc_btnd)
         acc <= calc_ref(acc, {cbus.calc_btnl, cbus.calc_btnc, cbus.calc_btnr}, cbus.calc_sw);
   end

   assign cbus.calc_led = (busy === 1'b1 && fault_mask[step] === 1'b1) ? (acc ^ fault_xor) : acc;

   // Pin monitor
   typedef struct {
      logic [2:0]  op;
      logic [15:0] sw;
      int          cyc;
   } obs_t;
   obs_t obs_q[$];
   int   cyc = 0, rst_cnt = 0, last_rst_cyc = 0, dbl_btnd = 0, idle_drv = 0;
   logic prev_btnd = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prev_btnd <= cbus.calc_btnd;
      if (cbus.calc_btnd === 1'b1) begin
         obs_q.push_back('{op: {cbus.calc_btnl, cbus.calc_btnc, cbus.calc_btnr},
                           sw: cbus.calc_sw, cyc: cyc});
         if (prev_btnd === 1'b1) dbl_btnd <= dbl_btnd + 1;
      end
      if (cbus.calc_rst === 1'b1) begin
         rst_cnt      <= rst_cnt + 1;
         last_rst_cyc <= cyc;
      end
      if (busy === 1'b0 && (cbus.calc_rst || cbus.calc_btnd || cbus.calc_btnl ||
                            cbus.calc_btnc || cbus.calc_btnr || cbus.calc_sw != 16'h0))
         idle_drv <= idle_drv + 1;
   end

   typedef struct {
      int          idx;
      logic [2:0]  op;
      logic [15:0] sw;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chk_drives_zero(input string tag);
      chk({tag, "_rst"}, cbus.calc_rst, 0);
      chk({tag, "_btnd"}, cbus.calc_btnd, 0);
      chk({tag, "_op"}, {cbus.calc_btnl, cbus.calc_btnc, cbus.calc_btnr}, 0);
      chk({tag, "_sw"}, cbus.calc_sw, 0);
   endtask

   // Pulses start, watches for done; optional start re-pulse or btnu abort at a given step.
   task automatic run(input int repulse_step, input int abort_step,
                      output int lat, output bit clr_ok, output bit aborted);
      bit rp = 0;
      lat = -1;
      aborted = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      clr_ok = (done === 1'b0 && pass === 1'b0 && busy === 1'b1);
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            break;
         end
         if (abort_step >= 0 && step == 4'(abort_step)) begin
            btnu = 1'b1;
            @(posedge clk);
            #1;
            btnu = 1'b0;
            aborted = 1;
            break;
         end
         if (repulse_step >= 0 && step == 4'(repulse_step) && !rp) begin
            start = 1'b1;
            rp = 1;
         end
      end
   endtask

   task automatic check_table(input int base, input string tag);
      chk({tag, "_pulses"}, obs_q.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < obs_q.size()) begin
            chk($sformatf("%s_op%0d", tag, tbl[i].idx), obs_q[base + i].op, tbl[i].op);
            chk($sformatf("%s_sw%0d", tag, tbl[i].idx), obs_q[base + i].sw, tbl[i].sw);
         end
      end
   endtask

   // Reference outcome of a run where the steps flagged in mask read back a wrong value.
   task automatic expect_run(input logic [8:0] mask, output int lat, output int err,
                             output int fidx, output int stp, output int pulses);
      int cnt = 0;
      fidx = 15;
      for (int i = 0; i < 9; i++)
         if (mask[i]) begin
            cnt++;
            if (fidx == 15) fidx = i;
         end
`ifdef CALC_SEQ_STOP_ON_FAIL_EN
      if (fidx != 15) begin
         lat = 1 + (fidx + 1) * 5;
         err = 1;
         stp = fidx;
         pulses = fidx + 1;
      end else begin
         lat = FULL_LAT;
         err = 0;
         stp = 8;
         pulses = 9;
      end
`else
      lat = FULL_LAT;
      err = (cnt > 15) ? 15 : cnt;
      stp = 8;
      pulses = 9;
`endif
   endtask

   initial begin
      int lat, base, rb, elat, eerr, efidx, estp, epulse;
      bit clr_ok, ab;
      logic [8:0] m;

      tbl[0] = '{0, 3'b010, 16'h354A};
      tbl[1] = '{1, 3'b011, 16'h1234};
      tbl[2] = '{2, 3'b001, 16'h1001};
      tbl[3] = '{3, 3'b000, 16'hF0F0};
      tbl[4] = '{4, 3'b111, 16'h1FA2};
      tbl[5] = '{5, 3'b010, 16'h6AA2};
      tbl[6] = '{6, 3'b101, 16'h0004};
      tbl[7] = '{7, 3'b110, 16'h0001};
      tbl[8] = '{8, 3'b100, 16'h46FF};

      // Reset, with start held high too: reset must win.
      btnu  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      btnu = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_step", step, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_fail_idx", fail_idx, 4'hF);
      chk_drives_zero("rst");
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);

      // Golden run
      base = obs_q.size();
      rb = rst_cnt;
      run(-1, -1, lat, clr_ok, ab);
      chk("gold_clear", clr_ok, 1);
      chk("gold_latency", lat, FULL_LAT);
      chk("gold_pass", pass, 1);
      chk("gold_err", err_cnt, 0);
      chk("gold_fail_idx", fail_idx, 4'hF);
      chk("gold_busy", busy, 0);
      chk("gold_step", step, 8);
      check_table(base, "gold");
      chk("gold_rst_pulses", rst_cnt - rb, 1);
      if (obs_q.size() > base) chk("gold_rst_before_step0", obs_q[base].cyc - last_rst_cyc, 2);
      chk("gold_btnd_double", dbl_btnd, 0);
      chk_drives_zero("done");

      // Restart from DONE: full repeat with identical results
      base = obs_q.size();
      run(-1, -1, lat, clr_ok, ab);
      chk("restart_clear", clr_ok, 1);
      chk("restart_latency", lat, FULL_LAT);
      chk("restart_pass", pass, 1);
      check_table(base, "restart");

      // Directed fault: led reads 3011 instead of 3010 at step 3
      base = obs_q.size();
      fault_mask = 16'h0008;
      fault_xor  = 16'h0001;
      expect_run(9'h008, elat, eerr, efidx, estp, epulse);
      run(-1, -1, lat, clr_ok, ab);
      fault_mask = '0;
      chk("fault3_latency", lat, elat);
      chk("fault3_err", err_cnt, eerr);
      chk("fault3_fail_idx", fail_idx, efidx);
      chk("fault3_pass", pass, 0);
      chk("fault3_step", step, estp);
      chk("fault3_pulses", obs_q.size() - base, epulse);

      // start re-pulsed during step 2 is ignored
      base = obs_q.size();
      run(2, -1, lat, clr_ok, ab);
      chk("repulse_latency", lat, FULL_LAT);
      chk("repulse_pass", pass, 1);
      chk("repulse_pulses", obs_q.size() - base, 9);

      // btnu during step 5 aborts to idle
      run(-1, 5, lat, clr_ok, ab);
      chk("abort_seen", ab, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_step", step, 0);
      chk("abort_fail_idx", fail_idx, 4'hF);
      chk_drives_zero("abort");
      repeat (2) @(posedge clk);
      run(-1, -1, lat, clr_ok, ab);
      chk("post_abort_latency", lat, FULL_LAT);
      chk("post_abort_pass", pass, 1);

      // Randomized fault patterns against the reference outcome
      for (int t = 0; t < 8; t++) begin
         m = ($urandom_range(0, 3) == 0) ? 9'h0 : 9'($urandom);
         fault_xor  = 16'($urandom_range(1, 16'hFFFF));
         fault_mask = {7'h0, m};
         expect_run(m, elat, eerr, efidx, estp, epulse);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         base = obs_q.size();
         run(-1, -1, lat, clr_ok, ab);
         fault_mask = '0;
         chk($sformatf("rnd%0d_latency", t), lat, elat);
         chk($sformatf("rnd%0d_err", t), err_cnt, eerr);
         chk($sformatf("rnd%0d_fail_idx", t), fail_idx, efidx);
         chk($sformatf("rnd%0d_pass", t), pass, (m == 9'h0) ? 1 : 0);
         chk($sformatf("rnd%0d_step", t), step, estp);
         chk($sformatf("rnd%0d_pulses", t), obs_q.size() - base, epulse);
      end

      chk("idle_drive_quiet", idle_drv, 0);
      chk("btnd_single_cycle", dbl_btnd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_seq.md
# calc_seq

Hardware self-test initiator for the `calc` block. On `start` it resets the calculator, then plays a fixed program of (opcode, operand, expected result) steps into calc's button/switch inputs. After each step it compares calc's `led` output with the expected value and reports pass/fail status. It sits beside `calc` on the board top, driving calc's inputs in place of the physical buttons and switches.

## Interface

Parameters:
- `WAIT_CYC`, 2: settle cycles between the `btnd` pulse and the result compare; legal range 1..15.
- `NUM_STEPS`, 9: program length; legal range 1..15; entries 0..NUM_STEPS-1 of the ROM are used.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `btnu` in 1: synchronous reset, active-high.
- `start` in 1: level; sampled each edge; acted on only in IDLE or DONE.
- `calc_led` in 16: calc result readback.
- `calc_rst` out 1: reset drive to calc.
- `calc_btnl` out 1, `calc_btnc` out 1, `calc_btnr` out 1: opcode drive to calc.
- `calc_btnd` out 1: execute pulse to calc.
- `calc_sw` out 16: operand drive to calc.
- `busy` out 1: high from the RST state through the last CHECK.
- `done` out 1: high in DONE; held until the next start or reset.
- `pass` out 1: valid with `done`; 1 iff `err_cnt` is 0.
- `step` out 4: current program index.
- `err_cnt` out 4: mismatch count, saturates at 15.
- `fail_idx` out 4: index of the first mismatch; 4'hF if none.

## Operation

- Opcode field `{l,c,r}` maps to `{calc_btnl,calc_btnc,calc_btnr}`:
  - ADD 010, SUB 011, OR 001, AND 000, XOR 111.
  - LSL 101, ASR 110, LT 100.
- ROM entries (op, sw, expected), starting from a cleared accumulator:
  - 0 ADD 354A→354A; 1 SUB 1234→2316; 2 OR 1001→3317.
  - 3 AND F0F0→3010; 4 XOR 1FA2→2FB2; 5 ADD 6AA2→9A54.
  - 6 LSL 0004→A540; 7 ASR 0001→D2A0; 8 LT 46FF→0001.
- FSM states: IDLE, RST, SETUP, FIRE, WAIT, CHECK, DONE.
  - IDLE, or DONE, with `start` → RST. This clears `err_cnt`, sets `fail_idx` to F, clears `done`/`pass` and sets `step` to 0.
  - RST: `calc_rst`=1 for one cycle → SETUP.
  - SETUP: drive the opcode and `calc_sw` for `step`; `calc_btnd`=0 → FIRE.
  - FIRE: `calc_btnd`=1 for exactly one cycle → WAIT.
  - WAIT: hold for WAIT_CYC cycles, using a 4-bit down-counter → CHECK.
  - CHECK: compare `calc_led` with the expected value; on mismatch, increment `err_cnt` and capture `fail_idx` if it is still F. Then go to SETUP with `step+1`, or to DONE if `step`=NUM_STEPS-1.
- Opcode and `calc_sw` are held stable from SETUP through CHECK. All calc drives are 0 in IDLE, RST (except `calc_rst`) and DONE.
- The compare is full 16-bit equality, with no masking.

## Timing

- Reset values:
  - All outputs 0, except `fail_idx`=4'hF.
  - State IDLE, WAIT counter 0.
- All outputs are registered and change only on a `clk` edge.
- Each step takes 3+WAIT_CYC cycles. Run latency: `done` rises 1+NUM_STEPS·(3+WAIT_CYC) edges after the edge that samples `start`. With defaults this is 46.
- `err_cnt`/`fail_idx` update on the edge that leaves CHECK.
- `start` while busy is ignored.
- `btnu` mid-run: the next edge forces reset values and IDLE. `calc_rst` is not pulsed; calc shares `btnu` at the top level.
- `btnu` and `start` high together: reset wins.

## Configuration

- `CALC_SEQ_STOP_ON_FAIL_EN` defined: the first mismatch goes CHECK → DONE directly. `step` freezes at the failing index, `err_cnt`=1 and `pass`=0.
- Not defined: all NUM_STEPS steps always execute, and errors accumulate (saturating).

## Test plan

- Reset: `btnu` high 1 cycle → all outputs 0, `fail_idx`=F, `busy`=0, all calc drives 0.
- Golden run with the real `calc` instance: `start` pulse → `done` 46 edges later, `pass`=1, `err_cnt`=0, `fail_idx`=F.
- Protocol, checked at the drive pins:
  - Step 1: `calc_sw`=1234, l/c/r=0/1/1.
  - Step 8: `calc_sw`=46FF, l/c/r=1/0/0.
  - `calc_btnd` is high exactly one cycle per step, 9 pulses total.
  - `calc_rst` is high exactly one cycle before step 0.
- Fault: force `calc_led`=3011 during CHECK of step 3.
  - Without the macro: `done` at 46, `err_cnt`=1, `fail_idx`=3, `pass`=0.
  - With the macro: `done` one edge after step-3 CHECK, `step`=3.
- Mid-run events:
  - `start` re-pulsed during step 2 → ignored.
  - `btnu` during step 5 → IDLE next edge, drives 0.
  - A fresh `start` then completes in 46 with `pass`=1.
- Restart: after `done`, `start` again → `done`/`pass` clear on the next edge, and the full run repeats with identical results.
